// File: rtl/ysyx_22050598_muldiv_iter.sv
// Iterative multiply/divide unit for the EXU: shift-add multiplier retiring MUL_STEP bits
// per cycle, radix-2 restoring divider, RV64M word mode and single-cycle divide fast paths.
module ysyx_22050598_muldiv_iter #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_div,
  input  logic [1:0]      mul_signed,
  input  logic            div_signed,
  input  logic            word,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int unsigned HALF = XLEN / 2;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_q, div_d, word_q, word_d;
  logic            neg_q, neg_d, aneg_q, aneg_d;
  logic [PW-1:0]   opa_q, opa_d, acc_q, acc_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, quo_q, quo_d, rem_q, rem_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic            a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_min;
  logic [PW-1:0]   mul_a, mul_sum, prod_fix;
  logic [XLEN-1:0] mul_b, quo_fix, rem_fix;
  logic [XLEN:0]   rem_sh, rem_sub;

  function automatic logic [XLEN-1:0] ext_half(input logic [XLEN-1:0] x, input logic sgn);
    return {{HALF{sgn & x[HALF-1]}}, x[HALF-1:0]};
  endfunction

  // Operand preparation: width extension, magnitudes, sign flags and fast-path detection
  always_comb begin
    a_sgn  = op_div ? div_signed : mul_signed[1];
    b_sgn  = op_div ? div_signed : (mul_signed == 2'b11);
    a_ext  = word ? ext_half(rs1, a_sgn) : rs1;
    b_ext  = word ? ext_half(rs2, b_sgn) : rs2;
    a_neg  = a_sgn & a_ext[XLEN-1];
    b_neg  = b_sgn & b_ext[XLEN-1];
    a_mag  = a_neg ? XLEN'(0) - a_ext : a_ext;
    b_mag  = b_neg ? XLEN'(0) - b_ext : b_ext;
    a_min  = word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    b_zero = (b_ext == '0);
    ovf    = div_signed & (a_ext == a_min) & (b_ext == '1);
  end

  // Next-state, datapath step and result formatting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    word_d  = word_q;
    neg_d   = neg_q;
    aneg_d  = aneg_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    mul_a   = opa_q;
    mul_b   = opb_q;
    mul_sum = acc_q;
    for (int unsigned j = 0; j < MUL_STEP; j++) begin
      if (mul_b[0]) mul_sum = mul_sum + mul_a;
      mul_a = mul_a << 1;
      mul_b = mul_b >> 1;
    end

    // Divider: acc low half is the partial remainder, opb shifts dividend out / quotient in
    rem_sh   = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
    rem_sub  = rem_sh - {1'b0, opa_q[XLEN-1:0]};
    prod_fix = neg_q ? PW'(0) - acc_q : acc_q;
    quo_fix  = neg_q ? XLEN'(0) - opb_q : opb_q;
    rem_fix  = aneg_q ? XLEN'(0) - acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    unique case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          div_d  = op_div;
          word_d = word;
          neg_d  = a_neg ^ b_neg;
          aneg_d = a_neg;
          acc_d  = '0;
          if (op_div && b_zero) begin
            quo_d   = '1;
            rem_d   = word ? ext_half(rs1, 1'b1) : rs1;
            state_d = DONE;
          end else if (op_div && ovf) begin
            quo_d   = a_ext;
            rem_d   = '0;
            state_d = DONE;
          end else if (op_div) begin
            opa_d   = PW'(b_mag);
            opb_d   = word ? a_mag << HALF : a_mag;
            cnt_d   = word ? CW'(HALF - 1) : CW'(XLEN - 1);
            state_d = CALC;
          end else begin
            opa_d   = PW'(a_mag);
            opb_d   = b_mag;
            cnt_d   = word ? CW'(HALF / MUL_STEP - 1) : CW'(XLEN / MUL_STEP - 1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (div_q) begin
            if (!rem_sub[XLEN]) begin
              acc_d = PW'(rem_sub[XLEN-1:0]);
              opb_d = {opb_q[XLEN-2:0], 1'b1};
            end else begin
              acc_d = PW'(rem_sh[XLEN-1:0]);
              opb_d = {opb_q[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_d = mul_sum;
            opa_d = mul_a;
            opb_d = mul_b;
          end
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (div_q) begin
            quo_d = word_q ? ext_half(quo_fix, 1'b1) : quo_fix;
            rem_d = word_q ? ext_half(rem_fix, 1'b1) : rem_fix;
          end else begin
            lo_d = word_q ? ext_half(prod_fix[XLEN-1:0], 1'b1) : prod_fix[XLEN-1:0];
            hi_d = word_q ? '0 : prod_fix[PW-1:XLEN];
          end
        end
      end
      DONE: begin
        if (flush || (out_valid_q && out_ready)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    // out_valid trails DONE entry by one cycle so results are always settled when it rises
    out_valid_d = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      aneg_q      <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      word_q      <= word_d;
      neg_q       <= neg_d;
      aneg_q      <= aneg_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result_hi = hi_q;
  assign result_lo = lo_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
